// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for reg_alu_sequencer.
//   op_e      : 3-bit opcode encoding of the ALU operations
//   state_e   : sequencer FSM states
//   DATA_W_DEF / ADDR_W_DEF : default word and register-address widths
//   MUL_ITERS : iteration count of the optional shift-add multiplier
package alu_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int MUL_ITERS  = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPR  = 2'd1,
        S_EXE  = 2'd2,
        S_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: sequential shift-add multiplier, one multiplier bit per cycle.
// Only instantiated when ALU_SEQ_MUL_EN is defined.
//   i_clk, i_rst      : clock, async active-high reset
//   i_start           : load operands (i_a, i_b) and begin MUL_ITERS iterations
//   o_done            : high during the last iteration cycle
//   o_product         : full product; valid (final) while o_done is high
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_product
);

    localparam int CNT_W = $clog2(MUL_ITERS);

    logic                r_run;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;

    logic [2*DATA_W-1:0] w_acc_nxt;
    logic                w_last;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last    = r_run && (r_cnt == CNT_W'(MUL_ITERS - 1));

    // The product is exposed combinationally on the last iteration so the
    // consumer can register it on the same edge the final partial sum lands.
    assign o_done    = w_last;
    assign o_product = w_acc_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last)
                r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_alu_sequencer.sv
// reg_alu_sequencer: single-issue execute/write-back stage around a 16x16
// register file. IDLE -> OPR (read operands) -> EXE (compute) -> WB (write).
// Optional macro: ALU_SEQ_MUL_EN enables opcode 7 (MUL) via alu_seq_mul;
// without it MUL is illegal: no write, flags held, done still pulses.
//   i_clk, i_rst                      : clock, async active-high reset
//   i_instr_valid / o_instr_ready     : instruction handshake (ready only in IDLE)
//   i_instr_op/rd/rs1/rs2             : opcode and register addresses
//   o_rf_read_addr1/2, i_rf_read_port1/2 : register file read side
//   o_rf_write_en/addr, o_rf_data_in  : register file write side
//   o_busy, o_done                    : not-IDLE, WB pulse
//   o_flag_zero, o_flag_carry         : flags of last written result
module reg_alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [2:0]        i_instr_op,
    input  logic [ADDR_W-1:0] i_instr_rd,
    input  logic [ADDR_W-1:0] i_instr_rs1,
    input  logic [ADDR_W-1:0] i_instr_rs2,
    output logic [ADDR_W-1:0] o_rf_read_addr1,
    output logic [ADDR_W-1:0] o_rf_read_addr2,
    input  logic [DATA_W-1:0] i_rf_read_port1,
    input  logic [DATA_W-1:0] i_rf_read_port2,
    output logic              o_rf_write_en,
    output logic [ADDR_W-1:0] o_rf_write_addr,
    output logic [DATA_W-1:0] o_rf_data_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_flag_zero,
    output logic              o_flag_carry
);

    state_e              r_state, w_state_nxt;
    op_e                 r_op;
    logic [ADDR_W-1:0]   r_rd, r_rs1, r_rs2;
    logic [DATA_W-1:0]   r_a, r_b, r_r;
    logic                r_carry_nxt;
    logic                r_flag_zero, r_flag_carry;

    logic [DATA_W-1:0]   w_res;
    logic                w_carry;
    logic [DATA_W:0]     w_sum, w_diff;
    logic [2*DATA_W-1:0] w_shl, w_shr;
    logic                w_exe_done;
    logic                w_legal;

`ifdef ALU_SEQ_MUL_EN
    logic                w_mul_done;
    logic [2*DATA_W-1:0] w_mul_prod;

    // Started while in OPR so the multiplier loads the same operands that
    // are being captured into A/B; its 16 iterations then fill EXE.
    alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   ((r_state == S_OPR) && (r_op == OP_MUL)),
        .i_a       (i_rf_read_port1),
        .i_b       (i_rf_read_port2),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    assign w_exe_done = (r_op != OP_MUL) || w_mul_done;
    assign w_legal    = 1'b1;
`else
    assign w_exe_done = 1'b1;
    assign w_legal    = (r_op != OP_MUL);
`endif

    // Outputs decode from registered state only.
    assign o_instr_ready   = (r_state == S_IDLE);
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = (r_state == S_WB);
    assign o_rf_write_en   = (r_state == S_WB) && w_legal;
    assign o_rf_write_addr = r_rd;
    assign o_rf_data_in    = r_r;
    assign o_rf_read_addr1 = r_rs1;
    assign o_rf_read_addr2 = r_rs2;
    assign o_flag_zero     = r_flag_zero;
    assign o_flag_carry    = r_flag_carry;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_instr_valid) w_state_nxt = S_OPR;
            S_OPR:  w_state_nxt = S_EXE;
            S_EXE:  if (w_exe_done) w_state_nxt = S_WB;
            S_WB:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ALU. Shifts are done in a double-width field so the last bit shifted
    // out lands at a fixed position (bit DATA_W for SHL, DATA_W-1 for SHR),
    // which is 0 automatically when the shift amount is 0.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_sum   = {1'b0, r_a} + {1'b0, r_b};
        w_diff  = {1'b0, r_a} - {1'b0, r_b};
        w_shl   = {{DATA_W{1'b0}}, r_a} << r_b[3:0];
        w_shr   = {r_a, {DATA_W{1'b0}}} >> r_b[3:0];
        case (r_op)
            OP_ADD: begin w_res = w_sum[DATA_W-1:0];  w_carry = w_sum[DATA_W];  end
            OP_SUB: begin w_res = w_diff[DATA_W-1:0]; w_carry = w_diff[DATA_W]; end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_SHL: begin w_res = w_shl[DATA_W-1:0];        w_carry = w_shl[DATA_W];   end
            OP_SHR: begin w_res = w_shr[2*DATA_W-1:DATA_W]; w_carry = w_shr[DATA_W-1]; end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                w_res   = w_mul_prod[DATA_W-1:0];
                w_carry = |w_mul_prod[2*DATA_W-1:DATA_W];
            end
`endif
            default: begin w_res = '0; w_carry = 1'b0; end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op         <= OP_ADD;
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_r          <= '0;
            r_carry_nxt  <= 1'b0;
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_instr_valid) begin
                    r_op  <= op_e'(i_instr_op);
                    r_rd  <= i_instr_rd;
                    r_rs1 <= i_instr_rs1;
                    r_rs2 <= i_instr_rs2;
                end
                S_OPR: begin
                    r_a <= i_rf_read_port1;
                    r_b <= i_rf_read_port2;
                end
                S_EXE: if (w_exe_done) begin
                    r_r         <= w_res;
                    r_carry_nxt <= w_carry;
                end
                S_WB: if (w_legal) begin
                    r_flag_zero  <= (r_r == '0);
                    r_flag_carry <= r_carry_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Bench for reg_alu_sequencer with a behavioural 16x16 register file.
// Directed cases plus randomized instructions against an arithmetic model.
module tb_reg_alu_sequencer;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [3:0]  rd = 4'd0, rs1 = 4'd0, rs2 = 4'd0;
    logic        rdy, we, busy, done, fz, fc;
    logic [3:0]  ra1, ra2, waddr;
    logic [15:0] rp1, rp2, din;

    logic [15:0] rf [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_addr = 4'd0;
    logic [15:0] bd_data = 16'd0;
    int          wr_cnt = 0;
    int          cyc = 0;

    logic [15:0] exp_rf [16];
    bit          exp_z = 1'b0, exp_c = 1'b0;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rp1 = rf[ra1];
    assign rp2 = rf[ra2];

    always @(posedge clk) begin
        if (bd_we) rf[bd_addr] <= bd_data;
        else if (we) begin
            rf[waddr] <= din;
            wr_cnt    <= wr_cnt + 1;
        end
    end

    reg_alu_sequencer dut (
        .i_clk(clk), .i_rst(rst),
        .i_instr_valid(valid), .o_instr_ready(rdy),
        .i_instr_op(op), .i_instr_rd(rd), .i_instr_rs1(rs1), .i_instr_rs2(rs2),
        .o_rf_read_addr1(ra1), .o_rf_read_addr2(ra2),
        .i_rf_read_port1(rp1), .i_rf_read_port2(rp2),
        .o_rf_write_en(we), .o_rf_write_addr(waddr), .o_rf_data_in(din),
        .o_busy(busy), .o_done(done), .o_flag_zero(fz), .o_flag_carry(fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference semantics straight from the opcode definitions.
    function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output bit c, output bit legal);
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint unsigned s  = ub % 16;
        longint unsigned p;
        legal = 1'b1; c = 1'b0; r = 16'd0;
        case (o)
            3'd0: begin p = ua + ub; r = 16'(p % 65536); c = (p >= 65536); end
            3'd1: begin r = 16'((ua + 65536 - ub) % 65536); c = (ua < ub); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = 16'((ua * (64'd1 << s)) % 65536); c = (s != 0) && (((ua >> (16 - s)) % 2) == 1); end
            3'd6: begin r = 16'(ua >> s); c = (s != 0) && (((ua >> (s - 1)) % 2) == 1); end
            default: begin
                if (MUL_EN) begin p = ua * ub; r = 16'(p % 65536); c = (p / 65536) != 0; end
                else legal = 1'b0;
            end
        endcase
    endfunction

    task automatic preload(input int idx, input logic [15:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 4'(idx); bd_data = v;
        @(negedge clk);
        bd_we = 1'b0;
        exp_rf[idx] = v;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"}, 32'(rdy), 32'd1);
        check({tag, ".busy"},  32'(busy), 32'd0);
        check({tag, ".done"},  32'(done), 32'd0);
        check({tag, ".we"},    32'(we), 32'd0);
        check({tag, ".ra1"},   32'(ra1), 32'd0);
        check({tag, ".ra2"},   32'(ra2), 32'd0);
        check({tag, ".waddr"}, 32'(waddr), 32'd0);
        check({tag, ".din"},   32'(din), 32'd0);
        check({tag, ".fz"},    32'(fz), 32'd0);
        check({tag, ".fc"},    32'(fc), 32'd0);
    endtask

    // Issue one instruction from IDLE and follow it until busy drops.
    // k counts falling edges after the accept edge; WB is expected at k=2
    // (k=17 for an enabled MUL), so the write lands at T3 (T18).
    task automatic do_op(input string tag, input logic [2:0] o, input int d, input int s1, input int s2);
        logic [15:0] r; bit c, legal;
        int done_at = -1, dcnt = 0, rdy_bad = 0, wr0, exp_lat;
        bit finished = 1'b0;
        model(o, exp_rf[s1], exp_rf[s2], r, c, legal);
        exp_lat = (MUL_EN && o == 3'd7) ? 17 : 2;
        @(negedge clk);
        check({tag, ".ready_in"}, 32'(rdy), 32'd1);
        op = o; rd = 4'(d); rs1 = 4'(s1); rs2 = 4'(s2); valid = 1'b1;
        wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (!busy) begin finished = 1'b1; break; end
            if (rdy) rdy_bad++;
            if (done) begin dcnt++; if (done_at < 0) done_at = k; end
        end
        check({tag, ".finished"}, 32'(finished), 32'd1);
        check({tag, ".done_cycle"}, 32'(done_at), 32'(exp_lat));
        check({tag, ".done_count"}, 32'(dcnt), 32'd1);
        check({tag, ".ready_low"}, 32'(rdy_bad), 32'd0);
        check({tag, ".writes"}, 32'(wr_cnt - wr0), legal ? 32'd1 : 32'd0);
        if (legal) begin
            exp_rf[d] = r; exp_z = (r == 16'd0); exp_c = c;
        end
        check({tag, ".rd"}, 32'(rf[d]), 32'(exp_rf[d]));
        check({tag, ".fz"}, 32'(fz), 32'(exp_z));
        check({tag, ".fc"}, 32'(fc), 32'(exp_c));
        check({tag, ".ready_out"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[$];
        int wr0;
        bit fin;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 16; i++) preload(i, 16'($urandom));

        // ADD overflow into bit 15, no carry
        preload(1, 16'h7FFF); preload(2, 16'h0001);
        do_op("add", 3'd0, 3, 1, 2);
        check("add.const", 32'(rf[3]), 32'h8000);

        // SUB borrow and zero result
        preload(1, 16'h0001); preload(2, 16'h0002);
        do_op("sub_borrow", 3'd1, 4, 1, 2);
        check("sub_borrow.const", 32'(rf[4]), 32'hFFFF);
        check("sub_borrow.carry", 32'(fc), 32'd1);
        do_op("sub_zero", 3'd1, 5, 2, 2);
        check("sub_zero.zflag", 32'(fz), 32'd1);

        // Shifts: carry from bit shifted out, zero-amount leaves value
        preload(1, 16'h8001); preload(2, 16'h0001);
        do_op("shl", 3'd5, 6, 1, 2);
        check("shl.const", 32'(rf[6]), 32'h0002);
        preload(11, 16'h0000);
        do_op("shr0", 3'd6, 12, 1, 11);
        check("shr0.const", 32'(rf[12]), 32'h8001);
        check("shr0.carry", 32'(fc), 32'd0);

        // rd aliases both sources
        preload(1, 16'h0003);
        do_op("alias", 3'd0, 1, 1, 1);
        check("alias.const", 32'(rf[1]), 32'h0006);

        // Back-to-back with valid held high: accepts 4 cycles apart
        @(negedge clk);
        op = 3'd0; rd = 4'd9; rs1 = 4'd1; rs2 = 4'd2; valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (rdy) acc.push_back(cyc);
            if (acc.size() == 2) break;
            @(negedge clk);
            if (acc.size() == 1) begin op = 3'd4; rd = 4'd10; rs1 = 4'd9; rs2 = 4'd3; end
        end
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        check("b2b.accepts", 32'(acc.size()), 32'd2);
        if (acc.size() == 2) check("b2b.spacing", 32'(acc[1] - acc[0]), 32'd4);
        fin = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) begin fin = 1'b1; break; end
            @(negedge clk);
        end
        check("b2b.finished", 32'(fin), 32'd1);
        exp_rf[9]  = exp_rf[1] + exp_rf[2];
        exp_rf[10] = exp_rf[9] ^ exp_rf[3];
        exp_z = (exp_rf[10] == 16'd0); exp_c = 1'b0;
        check("b2b.r9", 32'(rf[9]), 32'(exp_rf[9]));
        check("b2b.r10", 32'(rf[10]), 32'(exp_rf[10]));

        // Reset during EXE of XOR r7: abandoned, no write
        preload(7, 16'hA5A5);
        @(negedge clk);
        op = 3'd4; rd = 4'd7; rs1 = 4'd1; rs2 = 4'd2; valid = 1'b1;
        wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        exp_z = 1'b0; exp_c = 1'b0;
        check("rst_mid.no_write", 32'(wr_cnt - wr0), 32'd0);
        check("rst_mid.r7", 32'(rf[7]), 32'h0000A5A5);
        check("rst_mid.fz", 32'(fz), 32'(exp_z));

        // MUL: overflow to exactly zero low half
        preload(1, 16'h0100); preload(2, 16'h0100);
        do_op("mul", 3'd7, 8, 1, 2);

        // Randomized instructions
        for (int n = 0; n < 24; n++) begin
            if ((n % 6) == 0) preload(int'($urandom_range(0, 15)), 16'($urandom_range(0, 3)));
            do_op($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_alu_sequencer.md
# reg_alu_sequencer

Single-issue execute/write-back stage that sits directly downstream of the 16×16 register file's read ports and directly upstream of its write port. Accepts one register-to-register instruction through a valid/ready handshake, drives the two read addresses, captures the operands, computes the ALU result, and writes it back through the file's write port. It is the first block that closes the read-compute-write loop around the register file.

## Interface
- DATA_W, 16, operand/result width (matches register file word)
- ADDR_W, 4, register address width (16 registers)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept; high only in IDLE
- instr_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
- instr_rd / instr_rs1 / instr_rs2  in  ADDR_W each  destination / source registers
- rf_read_addr1, rf_read_addr2  out  ADDR_W  to register file read addresses
- rf_read_port1, rf_read_port2  in  DATA_W  from register file read ports, combinational
- rf_write_en  out  1  write strobe to register file
- rf_write_addr  out  ADDR_W  write address
- rf_data_in  out  DATA_W  write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in WB
- flag_zero, flag_carry  out  1  flags of the last written result

## Operation
- FSM: IDLE → OPR → EXE → WB → IDLE.
- IDLE: instr_ready=1. When instr_valid&instr_ready on an edge, latch op/rd/rs1/rs2 and go to OPR.
- OPR: rf_read_addr1/2 are driven from the latched rs1/rs2 and held at those values until the next accept. Capture rf_read_port1/2 into operand registers A/B; go to EXE.
- EXE: compute the result register R and the next flags.
  - ADD: R=A+B; carry=bit 16.
  - SUB: R=A−B; carry=1 iff A<B unsigned (borrow).
  - AND/OR/XOR: bitwise; carry=0.
  - SHL/SHR: logical shift of A by B[3:0]; carry=last bit shifted out (0 if B[3:0]=0).
  - MUL: see Configuration.
- WB: rf_write_en=1, rf_write_addr=latched rd, rf_data_in=R. Flags update to zero=(R==0) and the computed carry. done=1. Next state is IDLE.
- rd may equal rs1/rs2. Operands were captured in OPR, so the write always uses the old values.
- Reset, including mid-operation: the instruction is abandoned with no write. Reset values:
  - state IDLE, instr_ready 1, busy 0, done 0, rf_write_en 0
  - all addresses 0, rf_data_in 0, flags 0, A/B/R 0

## Timing
- Accept edge T0. Operands captured at T1. R registered at T2. Register file write at T3 (WB occupies the T2–T3 cycle).
- instr_ready returns high in the cycle after T3. Throughput is 1 instruction per 4 cycles for non-MUL ops.
- rf_write_en, done and busy decode from registered state only; no combinational path from instr_valid to any output.
- instr_valid held high continuously: the next instruction is accepted on the first edge after returning to IDLE.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL is a shift-add multiplier in EXE, 16 iterations, one bit per cycle.
  - EXE lasts 16 cycles, so the write lands at T18.
  - R = low 16 bits of A×B; carry=1 iff the high 16 bits are nonzero.
- ALU_SEQ_MUL_EN undefined: opcode 7 is illegal.
  - FSM still passes through EXE and WB with normal 3-edge latency.
  - rf_write_en stays 0 and flags are unchanged; done still pulses.

## Structure
- Package alu_seq_pkg:
  - opcode enum (OP_ADD … OP_MUL)
  - FSM state enum (S_IDLE, S_OPR, S_EXE, S_WB)
  - DATA_W/ADDR_W defaults
  - MUL iteration count constant
- One sub-module, alu_seq_mul (shift-add multiplier with start/done), instantiated only under ALU_SEQ_MUL_EN. The rest is flat.

## Test plan
Bench instantiates this block with the register file; registers are preloaded by backdoor.
- ADD r3=r1+r2, r1=0x7FFF, r2=0x0001 → at T3 r3=0x8000, zero=0, carry=0, done pulses once, instr_ready low T0–T3.
- SUB r4=r1−r2, r1=0x0001, r2=0x0002 → r4=0xFFFF, carry=1. SUB r5=r2−r2 → r5=0x0000, zero=1.
- SHL r6=r1<<r2, r1=0x8001, r2=0x0001 → r6=0x0002, carry=1. SHR with B=0 → unchanged value, carry=0.
- Aliasing ADD r1=r1+r1, r1=0x0003 → r1=0x0006. Back-to-back: instr_valid held high with 2 instructions → accepts exactly 4 cycles apart.
- rst asserted during EXE of XOR r7 → r7 keeps its old value, rf_write_en never asserted, all outputs at reset values immediately.
- MUL r8=r1×r2, 0x0100×0x0100: with ALU_SEQ_MUL_EN → r8=0x0000, carry=1, zero=1, write at T18. Without the macro → no write, done at T2–T3.
